pmc_shift_engine: RTL

Parametrised serial shift engine for the pixel matrix controller: generalises the fixed 32-channel × 16-bit matrix data path to CH_NUM channels of WIDTH bits. It generates the matrix shift strobe and shift clock with a programmable divider and shifts a parallel frame out while capturing the returning frame. Captured frames are buffered in a FIFO_DEPTH-deep frame FIFO with valid/ready readout and overflow flagging. It sits between the PMC register file (frame source/sink, control) and the matrix pads (`sh`, `pclk`, `pm_dout`, `pm_din`).

---
 rtl/pmc_shift_engine_if.sv | 54 +++++
 rtl/pmc_shift_engine.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pmc_shift_engine_if.sv
// ============================================================================
//  Module      : pmc_shift_engine_if
//  Description : Control, matrix pad and frame-readout bundle of the pixel
//                matrix shift engine.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pmc_shift_engine_if #(
  parameter int CH_NUM     = 32,
  parameter int WIDTH      = 16,
  parameter int DIV_W      = 8,
  parameter int FIFO_DEPTH = 4
) ();

  localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;

  // Transfer control
  logic                      start;
  logic                      msb_first;
  logic [DIV_W-1:0]          clk_div;
  logic [CH_NUM*WIDTH-1:0]   dout;
  logic                      busy;
  logic                      done;

  // Matrix pads
  logic                      sh;
  logic                      pclk;
  logic [CH_NUM-1:0]         pm_dout;
  logic [CH_NUM-1:0]         pm_din;

  // Captured frame readout
  logic                      rd_valid;
  logic                      rd_ready;
  logic [CH_NUM*WIDTH-1:0]   rd_data;
  logic [LEVEL_W-1:0]        fifo_level;
  logic                      overflow;
  logic                      clr_ovf;

  // Engine side
  modport slave (
    input  start, msb_first, clk_div, dout, pm_din, rd_ready, clr_ovf,
    output busy, done, sh, pclk, pm_dout, rd_valid, rd_data, fifo_level, overflow
  );

  // Register file / pad model side
  modport master (
    output start, msb_first, clk_div, dout, pm_din, rd_ready, clr_ovf,
    input  busy, done, sh, pclk, pm_dout, rd_valid, rd_data, fifo_level, overflow
  );

endinterface

`default_nettype wire

// File: rtl/pmc_shift_engine.sv
// ============================================================================
//  Module      : pmc_shift_engine
//  Description : Serial shift engine for the pixel matrix. Shifts a parallel
//                CH_NUM x WIDTH frame out on pm_dout under a divided pclk,
//                captures the returning frame from pm_din and buffers it in a
//                first-word fall-through frame FIFO with overflow flagging.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pmc_shift_engine #(
  parameter int CH_NUM     = 32,
  parameter int WIDTH      = 16,
  parameter int DIV_W      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pmc_shift_engine_if.slave    bus
);

  localparam int FRAME_W = CH_NUM * WIDTH;
  localparam int ADDR_W  = $clog2(FIFO_DEPTH);
  localparam int LEVEL_W = ADDR_W + 1;
  localparam int CNT_W   = $clog2(WIDTH + 1);

  localparam logic [CNT_W-1:0]   LAST_BIT   = CNT_W'(WIDTH - 1);
  localparam logic [LEVEL_W-1:0] FULL_LEVEL = LEVEL_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  state_t              r_state;
  state_t              w_state_nxt;

  logic                r_busy,  w_busy_nxt;
  logic                r_done,  w_done_nxt;
  logic                r_sh,    w_sh_nxt;
  logic                r_pclk,  w_pclk_nxt;

  logic [DIV_W-1:0]    r_half;      // captured clk_div: phase lasts r_half+1 cycles
  logic [DIV_W-1:0]    r_div_cnt;
  logic                r_phase;     // 0 = low phase, 1 = high phase
  logic                r_msb;
  logic [CNT_W-1:0]    r_bit_cnt;

  logic [WIDTH-1:0]    r_tx_sr [CH_NUM];
  logic [WIDTH-1:0]    r_rx_sr [CH_NUM];
  logic [CH_NUM-1:0]   r_pm_dout;
  logic [FRAME_W-1:0]  w_rx_frame;

  logic                w_load;
  logic                w_phase_end;
  logic                w_rise;
  logic                w_sample;
  logic                w_last;

  logic [FRAME_W-1:0]  r_mem [FIFO_DEPTH];
  logic [ADDR_W-1:0]   r_wr_ptr;
  logic [ADDR_W-1:0]   r_rd_ptr;
  logic [LEVEL_W-1:0]  r_level;
  logic                r_ovf;
  logic                w_push;
  logic                w_pop;
  logic                w_empty;
  logic                w_full;
  logic                w_wr_en;

  // --------------------------------------------------------------------------
  // Bit timing strobes
  // --------------------------------------------------------------------------
  assign w_load      = (r_state == IDLE) && bus.start;
  assign w_phase_end = (r_div_cnt == r_half);
  assign w_rise      = (r_state == SHIFT) && w_phase_end && !r_phase;
  assign w_sample    = (r_state == SHIFT) && w_phase_end &&  r_phase;
  assign w_last      = w_sample && (r_bit_cnt == LAST_BIT);

  // Next state and next values of the registered pad/status outputs
  always_comb begin
    w_state_nxt = r_state;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    w_sh_nxt    = 1'b0;
    w_pclk_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_state_nxt = SHIFT;
          w_busy_nxt  = 1'b1;
          w_sh_nxt    = 1'b1;
        end
      end
      SHIFT: begin
        w_busy_nxt = 1'b1;
        w_sh_nxt   = 1'b1;
        w_pclk_nxt = r_pclk;
        if (w_rise) begin
          w_pclk_nxt = 1'b1;
        end else if (w_sample) begin
          w_pclk_nxt = 1'b0;
        end
        // Busy stays high through the single DONE cycle
        if (w_last) begin
          w_state_nxt = DONE;
          w_sh_nxt    = 1'b0;
          w_done_nxt  = 1'b1;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State register and registered control outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sh    <= 1'b0;
      r_pclk  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_sh    <= w_sh_nxt;
      r_pclk  <= w_pclk_nxt;
    end
  end

  // Divider, phase and bit counters; transfer settings captured with start
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_half    <= '0;
      r_div_cnt <= '0;
      r_phase   <= 1'b0;
      r_msb     <= 1'b0;
      r_bit_cnt <= '0;
    end else if (w_load) begin
      r_half    <= bus.clk_div;
      r_div_cnt <= '0;
      r_phase   <= 1'b0;
      r_msb     <= bus.msb_first;
      r_bit_cnt <= '0;
    end else if (r_state == SHIFT) begin
      if (w_phase_end) begin
        r_div_cnt <= '0;
        r_phase   <= ~r_phase;
        if (w_sample) begin
          r_bit_cnt <= r_bit_cnt + CNT_W'(1);
        end
      end else begin
        r_div_cnt <= r_div_cnt + DIV_W'(1);
      end
    end
  end

  // Per-channel transmit/receive shift registers; the outgoing bit is
  // presented at start and then updated only when a new low phase begins
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < CH_NUM; c++) begin
        r_tx_sr[c] <= '0;
        r_rx_sr[c] <= '0;
      end
      r_pm_dout <= '0;
    end else if (w_load) begin
      for (int c = 0; c < CH_NUM; c++) begin
        r_tx_sr[c]   <= bus.dout[c*WIDTH +: WIDTH];
        r_rx_sr[c]   <= '0;
        r_pm_dout[c] <= bus.msb_first ? bus.dout[c*WIDTH + WIDTH - 1]
                                      : bus.dout[c*WIDTH];
      end
    end else if (w_sample) begin
      for (int c = 0; c < CH_NUM; c++) begin
        // First received bit ends up in the MSB (msb-first) or LSB
        if (r_msb) begin
          r_rx_sr[c] <= {r_rx_sr[c][WIDTH-2:0], bus.pm_din[c]};
        end else begin
          r_rx_sr[c] <= {bus.pm_din[c], r_rx_sr[c][WIDTH-1:1]};
        end
        if (!w_last) begin
          if (r_msb) begin
            r_tx_sr[c]   <= r_tx_sr[c] << 1;
            r_pm_dout[c] <= r_tx_sr[c][WIDTH-2];
          end else begin
            r_tx_sr[c]   <= r_tx_sr[c] >> 1;
            r_pm_dout[c] <= r_tx_sr[c][1];
          end
        end
      end
    end
  end

  // Re-pack the received channels into the bus frame layout
  for (genvar c = 0; c < CH_NUM; c++) begin : g_rx_pack
    assign w_rx_frame[c*WIDTH +: WIDTH] = r_rx_sr[c];
  end

  // --------------------------------------------------------------------------
  // Frame FIFO
  // --------------------------------------------------------------------------
  assign w_push  = (r_state == DONE);
  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == FULL_LEVEL);
  assign w_pop   = !w_empty && bus.rd_ready;
  // A simultaneous pop frees the head slot, so a full FIFO still accepts
  assign w_wr_en = w_push && (!w_full || w_pop);

  // Frame storage; contents are qualified by the level so no reset needed
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= w_rx_frame;
    end
  end

  // Pointers, level and sticky overflow (a new drop wins over clr_ovf)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      end
      case ({w_wr_en, w_pop})
        2'b10:   r_level <= r_level + LEVEL_W'(1);
        2'b01:   r_level <= r_level - LEVEL_W'(1);
        default: r_level <= r_level;
      endcase
      if (w_push && w_full && !w_pop) begin
        r_ovf <= 1'b1;
      end else if (bus.clr_ovf) begin
        r_ovf <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.sh         = r_sh;
  assign bus.pclk       = r_pclk;
  assign bus.pm_dout    = r_pm_dout;
  assign bus.rd_valid   = !w_empty;
  assign bus.rd_data    = w_empty ? '0 : r_mem[r_rd_ptr];
  assign bus.fifo_level = r_level;
  assign bus.overflow   = r_ovf;

endmodule

`default_nettype wire
